// File: rtl/pmem_types.sv
// Types and constants shared by the physical-memory burst responder and its storage.
package pmem_types;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} pmem_state_t;
    localparam int BEATS            = 4;
    localparam int BEAT_W           = 64;
    localparam int LINE_OFFSET_BITS = 5;
    typedef logic [BEAT_W-1:0] pmem_beat_t;
endpackage

// File: rtl/rv32i_types.sv
// Core-wide types shared with the memory side of the rv32i pipeline.
package rv32i_types;
    typedef logic [255:0] rv32i_line;
endpackage

// File: rtl/pmem_line_array.sv
// Line storage: 2**INDEX_BITS lines of four 64-bit lanes, one lane write port and
// one combinational lane read. Contents deliberately survive reset.
module pmem_line_array
    import pmem_types::*;
    import rv32i_types::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] w_index,
    input  logic [1:0]            w_beat,
    input  pmem_beat_t            w_data,
    input  logic [INDEX_BITS-1:0] r_index,
    input  logic [1:0]            r_beat,
    output pmem_beat_t            r_data
);
    localparam int DEPTH = 2 ** INDEX_BITS;

    rv32i_line lines_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            lines_q[w_index][{w_beat, 6'd0} +: BEAT_W] <= w_data;
        end
    end

    assign r_data = lines_q[r_index][{r_beat, 6'd0} +: BEAT_W];
endmodule

// File: rtl/pmem_burst_responder.sv
// Physical-memory responder for the 4-beat, 64-bit line burst port with a
// programmable access latency and a sticky protocol-violation flag.
module pmem_burst_responder
    import pmem_types::*;
#(
    parameter int LATENCY    = 8,
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        protocol_err,
    output pmem_state_t dbg_state
);
    // Handshake: the initiator holds mem_read/mem_write (and address) high from the
    // sampling edge until the 4th mem_resp beat; each mem_resp=1 cycle is one beat,
    // and the initiator moves mem_wdata on after every beat it sees.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
    localparam int         LINE_W = 32 - LINE_OFFSET_BITS;

    pmem_state_t       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              is_wr_q, is_wr_d;
    logic              resp_q, resp_d;
    pmem_beat_t        rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              req, changed, we;
    pmem_beat_t        rd_data;
    logic [4:0]        unused_offset;

    assign unused_offset = mem_addr[LINE_OFFSET_BITS-1:0];
    assign req     = mem_read | mem_write;
    assign changed = (mem_addr[31:LINE_OFFSET_BITS] != line_q) || (mem_write != is_wr_q);

    pmem_line_array #(.INDEX_BITS(INDEX_BITS)) u_array (
        .clk     (clk),
        .we      (we),
        .w_index (line_q[INDEX_BITS-1:0]),
        .w_beat  (beat_q),
        .w_data  (mem_wdata),
        .r_index (line_d[INDEX_BITS-1:0]),
        .r_beat  (beat_d),
        .r_data  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    line_d  = mem_addr[31:LINE_OFFSET_BITS];
                    is_wr_d = mem_write;
                    err_d   = err_q | (mem_read & mem_write);
                    cnt_d   = LAT_M1;
                    beat_d  = 2'd0;
                    state_d = (LATENCY == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d = err_q | changed;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = BURST;
                end
            end
            BURST: begin
                // A dropped request aborts before this beat commits.
                if (!req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d  = err_q | changed;
                    we     = is_wr_q;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so read data is looked up for the beat about to be shown.
        resp_d  = (state_d == BURST);
        rdata_d = (state_d == BURST && !is_wr_d) ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            is_wr_q <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            is_wr_q <= is_wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_resp     = resp_q;
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;
    assign dbg_state    = state_q;
endmodule

// File: doc/pmem_burst_responder.md
Name: pmem_burst_responder

Overview:
- Synthesizable physical-memory responder for the core's 64-bit, 4-beat burst memory port.
- Sits on the far side of the top-level mem_* bus and answers line reads and writes issued by the arbiter.
- Backs 256-bit lines with an internal array and adds a programmable access latency.
- Used as an FPGA/SoC memory stand-in and as the reference responder in system benches.

Parameters:
LATENCY, 8, clock edges from request sample to first data beat; legal range 1..255
INDEX_BITS, 6, log2 of the number of 256-bit lines stored (default 64 lines = 2 KiB)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
mem_read  input  1  line read request, held high by initiator until 4th beat
mem_write  input  1  line write request, held high by initiator until 4th beat
mem_addr  input  32  byte address; bits [4:0] ignored (line aligned)
mem_wdata  input  64  write beat; initiator advances it after each mem_resp beat
mem_rdata  output  64  read beat, valid only while mem_resp=1
mem_resp  output  1  beat strobe; high for exactly 4 consecutive cycles per burst
protocol_err  output  1  sticky protocol violation flag, cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, mem_resp=0, mem_rdata=0, protocol_err=0, counters=0. Array contents are not reset and survive reset.
- All outputs are registered.
- Line index = mem_addr[INDEX_BITS+4:5]. Upper address bits are ignored, so addresses alias modulo the array size.
- Beat k (0..3) carries line bits [64k+63:64k].
- States: IDLE, WAIT, BURST, RECOVER.
- IDLE:
  - On an edge with mem_read|mem_write=1, capture the operation and the index.
  - Load the latency counter with LATENCY-1. Go to WAIT, or go directly to BURST if LATENCY=1.
  - If mem_read and mem_write are both 1, treat the request as a write and set protocol_err.
- WAIT: decrement the counter each edge. At 0, go to BURST with beat=0.
- Latency: the first mem_resp=1 cycle starts exactly LATENCY edges after the sampling edge.
- BURST:
  - mem_resp=1 in every BURST cycle; beat increments each edge.
  - Read: mem_rdata = array[idx][beat] during that cycle.
  - Write: at the edge ending beat k, array[idx][k] <= mem_wdata.
  - After beat 3, go to RECOVER. mem_resp and mem_rdata return to 0 in that cycle.
- RECOVER:
  - One cycle in which requests are ignored, giving the initiator time to drop its request. Then go to IDLE.
  - A request still high in the following IDLE cycle is a new transaction.
- Request dropped before beat 3 (in WAIT or BURST): set protocol_err and go to IDLE. Words already written stay written.
- Captured address/operation: the captured index and operation are used for the whole burst. A mid-burst change of mem_addr or of the operation sets protocol_err but does not alter the burst.
- Read after write: a read of the same line after a write's RECOVER returns the newly written data.
- Asynchronous reset mid-burst: the burst is aborted immediately with no further beats. Partial write beats already committed remain.
- No request is accepted in WAIT, BURST or RECOVER. The responder never has more than one transaction outstanding.

Decomposition:
- Shared package pmem_types holds:
  - enum pmem_state_t {IDLE, WAIT, BURST, RECOVER}
  - localparam BEATS=4
  - localparam BEAT_W=64
  - localparam LINE_OFFSET_BITS=5
  - typedef pmem_beat_t (logic [63:0])
- The line type reuses rv32i_line from rv32i_types.
- Sub-module pmem_line_array holds the storage:
  - DEPTH=2**INDEX_BITS lines, organised as 4 x 64-bit lanes.
  - One write port (index, beat, data, we) and one combinational read (index, beat).
  - No reset.

Test Plan:
- Write then read, LATENCY=8: write addr 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Expect mem_resp high on cycles 8-11 after the sample edge.
  - A following read of 0x0000_0050 (same line) returns the same 4 beats in order on cycles 8-11.
- LATENCY=1 back-to-back: read 0x0 with the request held through RECOVER.
  - Expect resp cycles 1-4, one idle RECOVER cycle, then the second burst's resp exactly 1 cycle after its sample.
- Alias: with INDEX_BITS=6, write line at 0x0000_0800 and read 0x0000_0000.
  - Expect identical data (index wraps modulo 64).
- Both mem_read and mem_write asserted at address 0x20.
  - Expect a write burst to be performed and protocol_err=1, held until reset.
- Request dropped at beat 1 of a write.
  - Expect beat 0 committed, beats 1-3 unchanged, protocol_err=1, state back to IDLE next edge, no further mem_resp.
- rst=0 asserted mid-BURST of a read.
  - Expect mem_resp=0 and mem_rdata=0 immediately (asynchronous).
  - After rst=1, a read of a previously written line returns the preserved data.
